// File: rtl/icache_dm_pkg.sv
// Shared bus types and cache defaults for the direct-mapped instruction cache.
package icache_dm_pkg;

    localparam int ICACHE_SETS       = 64;
    localparam int ICACHE_LINE_WORDS = 4;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2
    } msize_t;

    // AXI-style length: number of beats minus one
    typedef logic [3:0] mlen_t;
    localparam mlen_t MLEN1  = 4'd0;
    localparam mlen_t MLEN2  = 4'd1;
    localparam mlen_t MLEN4  = 4'd3;
    localparam mlen_t MLEN8  = 4'd7;
    localparam mlen_t MLEN16 = 4'd15;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01
    } axi_burst_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        mlen_t       len;
        axi_burst_t  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REFILL   = 2'd1,
        UNCACHED = 2'd2
    } icache_state_t;

    function automatic mlen_t mlen_of(input int words);
        return mlen_t'(words - 1);
    endfunction

endpackage

// File: rtl/icache_dm_array.sv
// Flop-based data/tag/valid storage with a combinational read port and a single
// refill write port (one word per cycle plus tag/valid update).
module icache_dm_array
    import icache_dm_pkg::*;
#(
    parameter int SETS       = ICACHE_SETS,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int IDX_W      = $clog2(SETS),
    parameter int OFS_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1,
    parameter int TAG_W      = 32 - IDX_W - $clog2(LINE_WORDS) - 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFS_W-1:0] rd_ofs,
    output logic [31:0]      rd_data,
    output logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OFS_W-1:0] wr_ofs,
    input  logic [31:0]      wr_data,
    input  logic             tag_we,
    input  logic [TAG_W-1:0] tag_data,
    input  logic             inv_en,
    input  logic [IDX_W-1:0] inv_idx
);

    logic [31:0]      data_q [SETS][LINE_WORDS];
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [SETS-1:0]  valid_q;

    assign rd_data  = data_q[rd_idx][rd_ofs];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_valid = valid_q[rd_idx];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_idx][wr_ofs] <= wr_data;
        end
        if (tag_we) begin
            tag_q[wr_idx] <= tag_data;
        end
    end

    // Only the valid bits are reset; stale data/tags are harmless behind them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (tag_we) begin
            valid_q[wr_idx] <= 1'b1;
        end else if (inv_en) begin
            valid_q[inv_idx] <= 1'b0;
        end
    end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: same-cycle hits, whole-line INCR
// refills on miss, and single-word FIXED reads for kseg1 fetches.
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int SETS       = ICACHE_SETS,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp
);

    localparam int IDX_W = $clog2(SETS);
    localparam int OFS   = $clog2(LINE_WORDS);
    localparam int OFS_W = (OFS > 0) ? OFS : 1;
    localparam int TAG_W = 32 - IDX_W - OFS - 2;
    localparam int CNT_W = OFS + 1;
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS) * 32'd4 - 32'd1);

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
        return IDX_W'(a >> (OFS + 2));
    endfunction

    function automatic logic [OFS_W-1:0] addr_ofs(input logic [31:0] a);
        return OFS_W'((a >> 2) & 32'(LINE_WORDS - 1));
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
        return TAG_W'(a >> (OFS + IDX_W + 2));
    endfunction

    icache_state_t    state_q, state_d;
    logic [31:0]      addr_q;
    logic [CNT_W-1:0] cnt_q;

    logic [IDX_W-1:0] req_idx;
    logic [OFS_W-1:0] req_ofs;
    logic [TAG_W-1:0] req_tag;
    logic             uncached;
    logic             hit;
    logic             miss;
    logic [31:0]      rd_data;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_valid;
    logic             beat;
    logic             done;

    assign req_idx  = addr_idx(ireq.addr);
    assign req_ofs  = addr_ofs(ireq.addr);
    assign req_tag  = addr_tag(ireq.addr);
    assign uncached = (ireq.addr[31:29] == 3'b101);
    assign hit      = (state_q == IDLE) && ireq.valid && !uncached && rd_valid && (rd_tag == req_tag);
    assign miss     = (state_q == IDLE) && ireq.valid && !uncached && !hit;
    assign beat     = (state_q == REFILL) && cresp.ready;
    assign done     = cresp.ready && cresp.last;

    icache_dm_array #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W),
        .OFS_W      (OFS_W),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (req_idx),
        .rd_ofs   (req_ofs),
        .rd_data  (rd_data),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .wr_en    (beat),
        .wr_idx   (addr_idx(addr_q)),
        .wr_ofs   (OFS_W'(cnt_q)),
        .wr_data  (cresp.data),
        .tag_we   (beat && cresp.last),
        .tag_data (addr_tag(addr_q)),
        .inv_en   (miss),
        .inv_idx  (req_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Refill address is line-aligned; uncached address is kept whole.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (state_q == IDLE && ireq.valid && !hit) begin
                addr_q <= uncached ? ireq.addr : (ireq.addr & LINE_MASK);
            end
            if (beat) begin
                cnt_q <= cresp.last ? '0 : cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ireq.valid && uncached) begin
                    state_d = UNCACHED;
                end else if (miss) begin
                    state_d = REFILL;
                end
            end
            REFILL, UNCACHED: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        iresp = '0;
        creq  = '0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    iresp.addr_ok = 1'b1;
                    iresp.data_ok = 1'b1;
                    iresp.data    = rd_data;
                end
            end
            REFILL: begin
                creq.valid    = 1'b1;
                creq.is_write = 1'b0;
                creq.size     = MSIZE4;
                creq.addr     = addr_q;
                creq.strobe   = 4'b0000;
                creq.len      = mlen_of(LINE_WORDS);
                creq.burst    = AXI_BURST_INCR;
            end
            UNCACHED: begin
                creq.valid    = 1'b1;
                creq.is_write = 1'b0;
                creq.size     = MSIZE4;
                creq.addr     = addr_q;
                creq.strobe   = 4'b0000;
                creq.len      = MLEN1;
                creq.burst    = AXI_BURST_FIXED;
                // A fetch abandoned by the core still drains the bus read, but returns nothing.
                if (done && ireq.valid) begin
                    iresp.addr_ok = 1'b1;
                    iresp.data_ok = 1'b1;
                    iresp.data    = cresp.data;
                end
            end
            default: ;
        endcase
    end

`ifndef SYNTHESIS
    property p_last_on_final_word;
        @(posedge clk) disable iff (reset)
            (state_q == REFILL && cresp.ready && cresp.last) |-> (cnt_q == CNT_W'(LINE_WORDS - 1));
    endproperty
    assert property (p_last_on_final_word)
        else $error("icache_dm: burst ended at word %0d of a %0d-word line", cnt_q, LINE_WORDS);
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Randomized bench for icache_dm: a transaction-level cache/memory model checks
// every cycle, and directed fetches pin literal data and latencies.
module tb_icache_dm;
    import icache_dm_pkg::*;

    localparam int SETS = 64;
    localparam int LW   = 4;

    logic       clk = 1'b0;
    logic       reset;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    cbus_req_t  creq;
    cbus_resp_t cresp;

    icache_dm #(.SETS(SETS), .LINE_WORDS(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp),
        .creq  (creq),
        .cresp (cresp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int mode     = 0;
    int beat     = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Memory slave: INCR bursts walk successive words, FIXED reads one word.
    initial begin
        logic xfer;
        cresp = '0;
        forever begin
            @(negedge clk);
            xfer = creq.valid && cresp.ready && !reset;
            @(posedge clk);
            #1;
            if (reset) beat = 0;
            else if (xfer) beat = cresp.last ? 0 : beat + 1;
            if (creq.valid && !reset) begin
                case (mode)
                    0:       cresp.ready = 1'b1;
                    1:       cresp.ready = !cresp.ready;
                    default: cresp.ready = 1'($urandom_range(0, 1));
                endcase
                cresp.last = (beat == int'(creq.len));
                cresp.data = mem(creq.addr + ((creq.burst == AXI_BURST_INCR) ? 32'(beat * 4) : 32'd0));
            end else begin
                cresp.ready = 1'b0;
                cresp.last  = 1'b0;
                cresp.data  = $urandom();
            end
        end
    end

    // Reference model: which lines are resident, and which bus transaction is in flight.
    logic        m_valid [SETS];
    logic [31:0] m_tag   [SETS];
    int          m_busy;
    logic [31:0] m_addr;
    int          creq_starts = 0;
    logic [31:0] seen_addr;
    logic [3:0]  seen_len;
    logic [1:0]  seen_burst;

    initial begin
        logic        prev_cv;
        logic [31:0] a;
        logic [31:0] tg;
        logic [31:0] exp_data;
        logic        exp_ok;
        int          ix;
        prev_cv = 1'b0;
        m_busy  = 0;
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        forever begin
            @(negedge clk);
            exp_ok   = 1'b0;
            exp_data = '0;
            if (reset) begin
                check("rst_addr_ok", 32'(iresp.addr_ok), 32'd0);
                check("rst_data_ok", 32'(iresp.data_ok), 32'd0);
                check("rst_creq_valid", 32'(creq.valid), 32'd0);
                m_busy = 0;
                foreach (m_valid[i]) m_valid[i] = 1'b0;
            end else begin
                case (m_busy)
                    0: begin
                        check("idle_creq_valid", 32'(creq.valid), 32'd0);
                        if (ireq.valid) begin
                            a  = ireq.addr;
                            ix = int'((a / 32'(LW * 4)) % 32'(SETS));
                            tg = a / 32'(LW * 4 * SETS);
                            if (a[31:29] == 3'b101) begin
                                m_busy = 2;
                                m_addr = a;
                            end else if (m_valid[ix] && m_tag[ix] == tg) begin
                                exp_ok   = 1'b1;
                                exp_data = mem(a);
                            end else begin
                                m_busy     = 1;
                                m_addr     = a - (a % 32'(LW * 4));
                                m_valid[ix] = 1'b0;
                            end
                        end
                    end
                    1: begin
                        check("refill_valid", 32'(creq.valid), 32'd1);
                        check("refill_addr", creq.addr, m_addr);
                        check("refill_len", 32'(creq.len), 32'(LW - 1));
                        check("refill_burst", 32'(creq.burst), 32'(AXI_BURST_INCR));
                        check("refill_rd", 32'({creq.is_write, creq.size}), 32'({1'b0, MSIZE4}));
                        if (cresp.ready && cresp.last) begin
                            ix = int'((m_addr / 32'(LW * 4)) % 32'(SETS));
                            m_valid[ix] = 1'b1;
                            m_tag[ix]   = m_addr / 32'(LW * 4 * SETS);
                            m_busy      = 0;
                        end
                    end
                    default: begin
                        check("unc_valid", 32'(creq.valid), 32'd1);
                        check("unc_addr", creq.addr, m_addr);
                        check("unc_len", 32'(creq.len), 32'd0);
                        check("unc_burst", 32'(creq.burst), 32'(AXI_BURST_FIXED));
                        if (cresp.ready && cresp.last) begin
                            exp_ok   = ireq.valid;
                            exp_data = mem(m_addr);
                            m_busy   = 0;
                        end
                    end
                endcase
                check("addr_ok", 32'(iresp.addr_ok), 32'(exp_ok));
                check("data_ok", 32'(iresp.data_ok), 32'(exp_ok));
                if (exp_ok) check("resp_data", iresp.data, exp_data);
            end
            if (creq.valid && !prev_cv) begin
                creq_starts++;
                seen_addr  = creq.addr;
                seen_len   = creq.len;
                seen_burst = creq.burst;
            end
            prev_cv = creq.valid;
        end
    end

    task automatic wait_ok(input string name, output logic [31:0] d, output int lat);
        bit ok;
        ok  = 1'b0;
        lat = 0;
        d   = '0;
        while (!ok && lat < 300) begin
            @(negedge clk);
            if (iresp.addr_ok) begin
                ok = 1'b1;
                d  = iresp.data;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        ireq.valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout: no addr_ok after %0d cycles, required within 300", name, lat);
        end
    endtask

    task automatic fetch(input string name, input logic [31:0] a, output logic [31:0] d, output int lat);
        ireq.valid = 1'b1;
        ireq.addr  = a;
        wait_ok(name, d, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] a;
        int          lat;
        int          starts;
        int          k;
        reset = 1'b1;
        ireq  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        fetch("cold", 32'h8000_0010, d, lat);
        check("cold_data", d, 32'h5EAD_BEFF);
        check("cold_latency", 32'(lat), 32'd6);
        check("cold_creq_addr", seen_addr, 32'h8000_0010);
        check("cold_creq_len", 32'(seen_len), 32'd3);
        check("cold_creq_burst", 32'(seen_burst), 32'(AXI_BURST_INCR));

        starts = creq_starts;
        fetch("hit1", 32'h8000_0014, d, lat);
        check("hit1_data", d, 32'h5EAD_BEFB);
        check("hit1_latency", 32'(lat), 32'd1);
        fetch("hit3", 32'h8000_001C, d, lat);
        check("hit3_data", d, 32'h5EAD_BEF3);
        check("hit3_latency", 32'(lat), 32'd1);
        check("hit_no_creq", 32'(creq_starts), 32'(starts));

        fetch("conflict_a", 32'h8000_0410, d, lat);
        check("conflict_a_data", d, 32'h5EAD_BAFF);
        check("conflict_a_latency", 32'(lat), 32'd6);
        fetch("conflict_b", 32'h8000_0010, d, lat);
        check("conflict_b_data", d, 32'h5EAD_BEFF);
        check("conflict_b_latency", 32'(lat), 32'd6);

        fetch("unc1", 32'hBFC0_0000, d, lat);
        check("unc1_data", d, 32'h616D_BEEF);
        check("unc1_latency", 32'(lat), 32'd2);
        check("unc1_len", 32'(seen_len), 32'd0);
        check("unc1_burst", 32'(seen_burst), 32'(AXI_BURST_FIXED));
        starts = creq_starts;
        fetch("unc2", 32'hBFC0_0000, d, lat);
        check("unc2_latency", 32'(lat), 32'd2);
        check("unc2_new_creq", 32'(creq_starts), 32'(starts + 1));

        // Reset lands after two beats of a refill.
        ireq.valid = 1'b1;
        ireq.addr  = 32'h8000_0830;
        k = 0;
        do begin
            @(posedge clk);
            #2;
            k++;
        end while (beat != 2 && k < 50);
        check("midrst_reached_beat2", 32'(beat), 32'd2);
        reset = 1'b1;
        #1;
        check("midrst_creq_immediate", 32'(creq.valid), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        starts = creq_starts;
        wait_ok("midrst", d, lat);
        check("midrst_data", d, 32'h5EAD_B6DF);
        check("midrst_latency", 32'(lat), 32'd6);
        check("midrst_one_refill", 32'(creq_starts), 32'(starts + 1));

        mode = 1;
        fetch("bp", 32'h8000_0820, d, lat);
        check("bp_data", d, 32'h5EAD_B6CF);
        check("bp_latency", 32'(lat), 32'd9);
        mode = 0;
        for (int w = 1; w < LW; w++) begin
            a = 32'h8000_0820 + 32'(w * 4);
            fetch("bp_hit", a, d, lat);
            check("bp_hit_data", d, mem(a));
            check("bp_hit_latency", 32'(lat), 32'd1);
        end

        mode = 2;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 4))
                0:       a = 32'h8000_0000;
                1:       a = 32'h8000_0400;
                2:       a = 32'h9FC0_1000;
                3:       a = 32'hBFC0_0100;
                default: a = 32'hA000_0000;
            endcase
            a = a + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3) * 16);
            if ($urandom_range(0, 9) == 0) begin
                // Core abandons the fetch after one cycle; the bus transaction must still drain.
                ireq.valid = 1'b1;
                ireq.addr  = a;
                @(posedge clk);
                #1;
                ireq.valid = 1'b0;
                k = 0;
                while (creq.valid && k < 200) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
                check("drop_drained", 32'(creq.valid), 32'd0);
            end else begin
                fetch("rand", a, d, lat);
                check("rand_data", d, mem(a));
            end
        end
        mode = 0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
